// File: rtl/baralho_shoe.sv
// Multi-deck card shoe: rebuilds an ordered shoe after reset, shuffles it in place
// with rejection-sampled Fisher-Yates driven by a Galois LFSR, and deals sequentially.
module baralho_shoe #(
    parameter int unsigned NUM_DECKS = 2,
    parameter int unsigned CUT_CARDS = 26,
    parameter logic [15:0] SEED      = 16'hACE1
) (
    input  logic                              clock,
    input  logic                              reset,
    input  logic                              shuffle_start,
    input  logic                              deal_req,
    output logic                              deal_valid,
    output logic [3:0]                        deal_card,
    output logic                              deal_empty,
    output logic                              busy,
    output logic                              shuffled,
    output logic [$clog2(52*NUM_DECKS):0]     cards_left,
    output logic                              low_cards
);

    localparam int unsigned N  = 52 * NUM_DECKS;
    localparam int unsigned AW = $clog2(N);
    localparam int unsigned CW = AW + 1;
    localparam logic [15:0] TAPS = 16'hB400;

    typedef enum logic [2:0] {
        S_FILL,
        S_IDLE,
        S_READY,
        S_DRAW,
        S_SWAP
    } state_t;

    state_t          state;
    logic [15:0]     lfsr;
    logic [3:0]      mem [N];
    logic [AW-1:0]   k;
    logic [3:0]      mod13;
    logic [CW-1:0]   ptr;
    logic [AW-1:0]   i;
    logic [AW-1:0]   j;

    logic [15:0]     lfsr_next;
    logic [AW-1:0]   rnd;
    logic [AW-1:0]   mask;
    logic [AW-1:0]   cand;
    logic [3:0]      fill_val;
    logic            ptr_full;
    logic [CW-1:0]   left_dec;

    assign lfsr_next = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? TAPS : 16'h0000);
    assign rnd       = lfsr[AW-1:0];

    // Smallest all-ones value covering i, so candidates are drawn from [0, 2^ceil(log2(i+1)))
    always_comb begin
        mask = i;
        for (int s = 1; s < int'(AW); s++) begin
            mask = mask | (i >> s);
        end
    end

    assign cand     = rnd & mask;
    assign ptr_full = (ptr == CW'(N));
    assign left_dec = cards_left - CW'(1);

    always_comb begin
        fill_val = 4'd11;
        if (mod13 == 4'd0) begin
            fill_val = 4'd1;
        end else if (mod13 <= 4'd9) begin
            fill_val = mod13 + 4'd1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= S_FILL;
            lfsr       <= SEED;
            k          <= '0;
            mod13      <= '0;
            ptr        <= '0;
            i          <= '0;
            j          <= '0;
            deal_valid <= 1'b0;
            deal_empty <= 1'b0;
            deal_card  <= '0;
            busy       <= 1'b1;
            shuffled   <= 1'b0;
            cards_left <= CW'(N);
            low_cards  <= 1'b0;
        end else begin
            lfsr       <= lfsr_next;
            deal_valid <= 1'b0;
            deal_empty <= 1'b0;
            deal_card  <= '0;
            case (state)
                S_FILL: begin
                    mem[k] <= fill_val;
                    if (k == AW'(N - 1)) begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end else begin
                        k     <= k + AW'(1);
                        mod13 <= (mod13 == 4'd12) ? 4'd0 : mod13 + 4'd1;
                    end
                end
                S_IDLE, S_READY: begin
                    // A shuffle request takes priority over a same-cycle deal
                    if (shuffle_start) begin
                        ptr        <= '0;
                        cards_left <= CW'(N);
                        low_cards  <= 1'b0;
                        shuffled   <= 1'b0;
                        i          <= AW'(N - 1);
                        busy       <= 1'b1;
                        state      <= S_DRAW;
                    end else if (deal_req) begin
                        deal_valid <= 1'b1;
                        if (ptr_full) begin
                            deal_empty <= 1'b1;
                        end else begin
                            deal_card  <= mem[ptr[AW-1:0]];
                            ptr        <= ptr + CW'(1);
                            cards_left <= left_dec;
                            low_cards  <= (left_dec <= CW'(CUT_CARDS));
                        end
                    end
                end
                S_DRAW: begin
                    if (cand <= i) begin
                        j     <= cand;
                        state <= S_SWAP;
                    end
                end
                S_SWAP: begin
                    mem[i] <= mem[j];
                    mem[j] <= mem[i];
                    if (i == AW'(1)) begin
                        state    <= S_READY;
                        shuffled <= 1'b1;
                        busy     <= 1'b0;
                    end else begin
                        i     <= i - AW'(1);
                        state <= S_DRAW;
                    end
                end
                default: state <= S_FILL;
            endcase
        end
    end

endmodule

// File: tb/tb_baralho_shoe.sv
// Scoreboard bench for baralho_shoe: one-deck and two-deck instances on a shared clock.
module tb_baralho_shoe;

    localparam int unsigned N1 = 52;
    localparam int unsigned N2 = 104;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic       rst1, ss1, dr1, dv1, de1, busy1, sh1, low1;
    logic [3:0] dc1;
    logic [6:0] cl1;

    logic       rst2, ss2, dr2, dv2, de2, busy2, sh2, low2;
    logic [3:0] dc2;
    logic [7:0] cl2;

    baralho_shoe #(.NUM_DECKS(1), .CUT_CARDS(26), .SEED(16'hACE1)) dut1 (
        .clock(clock), .reset(rst1), .shuffle_start(ss1), .deal_req(dr1),
        .deal_valid(dv1), .deal_card(dc1), .deal_empty(de1), .busy(busy1),
        .shuffled(sh1), .cards_left(cl1), .low_cards(low1)
    );

    baralho_shoe #(.NUM_DECKS(2), .CUT_CARDS(26), .SEED(16'hACE1)) dut2 (
        .clock(clock), .reset(rst2), .shuffle_start(ss2), .deal_req(dr2),
        .deal_valid(dv2), .deal_card(dc2), .deal_empty(de2), .busy(busy2),
        .shuffled(sh2), .cards_left(cl2), .low_cards(low2)
    );

    int n_cmp = 0;
    int n_bad = 0;

    logic [3:0] exp_card_q [$];
    int         exp_left_q [$];
    logic [3:0] seq   [N2];
    logic [3:0] seq_a [N2];

    function automatic logic [3:0] fill_value(input int k);
        int m;
        m = k % 13;
        if (m == 0) return 4'd1;
        if (m <= 9) return 4'(m + 1);
        return 4'd11;
    endfunction

    // Stimulus helpers: start and end on a falling edge
    task automatic pulse_deal1();
        dr1 = 1'b1;
        @(negedge clock);
        dr1 = 1'b0;
    endtask

    task automatic pulse_deal2();
        dr2 = 1'b1;
        @(negedge clock);
        dr2 = 1'b0;
    endtask

    task automatic count_busy2(output int cnt);
        cnt = 0;
        while (busy2 && cnt < 1000) begin
            @(negedge clock);
            cnt++;
        end
    endtask

    task automatic wait_shuffled2(output int cyc);
        cyc = 0;
        while (!sh2 && cyc < 20000) begin
            @(negedge clock);
            cyc++;
        end
    endtask

    task automatic test_reset();
        rst1 = 1'b1; rst2 = 1'b1;
        @(negedge clock);
        @(negedge clock);
        n_cmp++;
        if ({dv1, de1, dc1, sh1, busy1, low1} !== {1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0}) begin
            n_bad++;
            $display("FAIL reset_flags1: got dv=%b de=%b card=%0d sh=%b busy=%b low=%b, required 0 0 0 0 1 0",
                     dv1, de1, dc1, sh1, busy1, low1);
        end
        n_cmp++;
        if (cl1 !== 7'd52) begin
            n_bad++;
            $display("FAIL reset_left1: got %0d required 52", cl1);
        end
        n_cmp++;
        if ({dv2, de2, dc2, sh2, busy2, low2} !== {1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0}) begin
            n_bad++;
            $display("FAIL reset_flags2: got dv=%b de=%b card=%0d sh=%b busy=%b low=%b, required 0 0 0 0 1 0",
                     dv2, de2, dc2, sh2, busy2, low2);
        end
        n_cmp++;
        if (cl2 !== 8'd104) begin
            n_bad++;
            $display("FAIL reset_left2: got %0d required 104", cl2);
        end
        rst1 = 1'b0; rst2 = 1'b0;
    endtask

    task automatic test_fill_order1();
        int cnt;
        logic [3:0] c;
        int l;
        cnt = 0;
        while (busy1 && cnt < 1000) begin
            @(negedge clock);
            cnt++;
        end
        n_cmp++;
        if (cnt !== 52) begin
            n_bad++;
            $display("FAIL fill_cycles1: got %0d required 52", cnt);
        end
        n_cmp++;
        if ({busy1, sh1, cl1} !== {1'b0, 1'b0, 7'd52}) begin
            n_bad++;
            $display("FAIL fill_done1: got busy=%b sh=%b left=%0d, required 0 0 52", busy1, sh1, cl1);
        end
        for (int k = 0; k < 13; k++) begin
            exp_card_q.push_back(fill_value(k));
            exp_left_q.push_back(int'(N1) - k - 1);
            pulse_deal1();
            c = exp_card_q.pop_front();
            l = exp_left_q.pop_front();
            n_cmp++;
            if ({dv1, de1, dc1, cl1} !== {1'b1, 1'b0, c, 7'(l)}) begin
                n_bad++;
                $display("FAIL ordered1_%0d: got dv=%b de=%b card=%0d left=%0d, required 1 0 %0d %0d",
                         k, dv1, de1, dc1, cl1, c, l);
            end
        end
    endtask

    task automatic check_ordered2(input string tag);
        logic [3:0] c;
        int l;
        for (int k = 0; k < 13; k++) begin
            exp_card_q.push_back(fill_value(k));
            exp_left_q.push_back(int'(N2) - k - 1);
            pulse_deal2();
            c = exp_card_q.pop_front();
            l = exp_left_q.pop_front();
            n_cmp++;
            if ({dv2, de2, dc2, cl2} !== {1'b1, 1'b0, c, 8'(l)}) begin
                n_bad++;
                $display("FAIL %s_%0d: got dv=%b de=%b card=%0d left=%0d, required 1 0 %0d %0d",
                         tag, k, dv2, de2, dc2, cl2, c, l);
            end
        end
    endtask

    task automatic deal_out(input string tag);
        int hist [12];
        int l;
        int diffs;
        int expv;
        for (int v = 0; v < 12; v++) hist[v] = 0;
        diffs = 0;
        for (int k = 0; k < int'(N2); k++) begin
            exp_left_q.push_back(int'(N2) - k - 1);
            pulse_deal2();
            l = exp_left_q.pop_front();
            n_cmp++;
            if ({dv2, de2, cl2, low2} !== {1'b1, 1'b0, 8'(l), 1'(l <= 26)}) begin
                n_bad++;
                $display("FAIL %s_deal%0d: got dv=%b de=%b left=%0d low=%b, required 1 0 %0d %b",
                         tag, k, dv2, de2, cl2, low2, l, (l <= 26));
            end
            seq[k] = dc2;
            if (dc2 < 4'd12) hist[dc2]++;
            else hist[0]++;
            if (dc2 !== fill_value(k)) diffs++;
        end
        for (int v = 0; v < 12; v++) begin
            expv = (v == 0) ? 0 : ((v == 11) ? 24 : 8);
            n_cmp++;
            if (hist[v] !== expv) begin
                n_bad++;
                $display("FAIL %s_hist%0d: got %0d cards required %0d", tag, v, hist[v], expv);
            end
        end
        n_cmp++;
        if (diffs == 0) begin
            n_bad++;
            $display("FAIL %s_order: got 0 positions differing from unshuffled order, required > 0", tag);
        end
    endtask

    task automatic test_shuffle();
        int cnt;
        int cyc;
        count_busy2(cnt);
        n_cmp++;
        if (busy2 !== 1'b0) begin
            n_bad++;
            $display("FAIL fill2_timeout: busy=%b after %0d cycles, required 0", busy2, cnt);
        end
        ss2 = 1'b1;
        @(negedge clock);
        ss2 = 1'b0;
        n_cmp++;
        if ({busy2, sh2} !== 2'b10) begin
            n_bad++;
            $display("FAIL shuffle_busy: got busy=%b sh=%b, required 1 0", busy2, sh2);
        end
        wait_shuffled2(cyc);
        n_cmp++;
        if (sh2 !== 1'b1) begin
            n_bad++;
            $display("FAIL shuffle_timeout: shuffled=%b after %0d cycles, required 1", sh2, cyc);
        end
        n_cmp++;
        if (cyc < 206) begin
            n_bad++;
            $display("FAIL shuffle_cycles: got %0d required >= 206", cyc);
        end
        deal_out("first");
    endtask

    task automatic test_empty();
        pulse_deal2();
        n_cmp++;
        if ({dv2, de2, dc2, cl2, low2} !== {1'b1, 1'b1, 4'd0, 8'd0, 1'b1}) begin
            n_bad++;
            $display("FAIL empty_deal: got dv=%b de=%b card=%0d left=%0d low=%b, required 1 1 0 0 1",
                     dv2, de2, dc2, cl2, low2);
        end
        @(negedge clock);
        n_cmp++;
        if ({dv2, de2} !== 2'b00) begin
            n_bad++;
            $display("FAIL empty_pulse: got dv=%b de=%b one cycle later, required 0 0", dv2, de2);
        end
    endtask

    task automatic test_collision();
        ss2 = 1'b1; dr2 = 1'b1;
        @(negedge clock);
        ss2 = 1'b0; dr2 = 1'b0;
        n_cmp++;
        if ({dv2, busy2, sh2, cl2} !== {1'b0, 1'b1, 1'b0, 8'd104}) begin
            n_bad++;
            $display("FAIL collision: got dv=%b busy=%b sh=%b left=%0d, required 0 1 0 104",
                     dv2, busy2, sh2, cl2);
        end
    endtask

    task automatic test_busy_ignore();
        int cyc;
        for (int c = 0; c < 10; c++) begin
            dr2 = 1'b1;
            ss2 = c[0];
            @(negedge clock);
            n_cmp++;
            if ({dv2, de2, cl2} !== {1'b0, 1'b0, 8'd104}) begin
                n_bad++;
                $display("FAIL busy_ignore%0d: got dv=%b de=%b left=%0d, required 0 0 104", c, dv2, de2, cl2);
            end
        end
        dr2 = 1'b0; ss2 = 1'b0;
        wait_shuffled2(cyc);
        n_cmp++;
        if (sh2 !== 1'b1) begin
            n_bad++;
            $display("FAIL busy_shuffle_timeout: shuffled=%b after %0d cycles, required 1", sh2, cyc);
        end
        deal_out("second");
    endtask

    // Reset during a shuffle, verify the ordered rebuild, then shuffle at a fixed distance from reset
    task automatic run_mid_reset(input string tag);
        int cnt;
        int cyc;
        ss2 = 1'b1;
        @(negedge clock);
        ss2 = 1'b0;
        repeat (50) @(negedge clock);
        n_cmp++;
        if ({busy2, sh2} !== 2'b10) begin
            n_bad++;
            $display("FAIL %s_midshuffle: got busy=%b sh=%b, required 1 0", tag, busy2, sh2);
        end
        rst2 = 1'b1;
        @(negedge clock);
        @(negedge clock);
        rst2 = 1'b0;
        count_busy2(cnt);
        n_cmp++;
        if (cnt !== 104) begin
            n_bad++;
            $display("FAIL %s_refill: got %0d busy cycles required 104", tag, cnt);
        end
        n_cmp++;
        if ({sh2, cl2} !== {1'b0, 8'd104}) begin
            n_bad++;
            $display("FAIL %s_refill_state: got sh=%b left=%0d, required 0 104", tag, sh2, cl2);
        end
        check_ordered2({tag, "_ordered"});
        repeat (20) @(negedge clock);
        ss2 = 1'b1;
        @(negedge clock);
        ss2 = 1'b0;
        wait_shuffled2(cyc);
        n_cmp++;
        if (sh2 !== 1'b1) begin
            n_bad++;
            $display("FAIL %s_shuffle_timeout: shuffled=%b after %0d cycles, required 1", tag, sh2, cyc);
        end
        deal_out(tag);
    endtask

    task automatic test_determinism();
        int diffs;
        run_mid_reset("runa");
        for (int k = 0; k < int'(N2); k++) seq_a[k] = seq[k];
        run_mid_reset("runb");
        diffs = 0;
        for (int k = 0; k < int'(N2); k++) begin
            if (seq[k] !== seq_a[k]) diffs++;
        end
        n_cmp++;
        if (diffs != 0) begin
            n_bad++;
            $display("FAIL determinism: got %0d differing positions between runs, required 0", diffs);
        end
    endtask

    initial begin
        rst1 = 1'b1; ss1 = 1'b0; dr1 = 1'b0;
        rst2 = 1'b1; ss2 = 1'b0; dr2 = 1'b0;
        @(negedge clock);
        test_reset();
        test_fill_order1();
        test_shuffle();
        test_empty();
        test_collision();
        test_busy_ignore();
        test_determinism();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/baralho_shoe.md
Name: baralho_shoe

Overview:
- Parametrised multi-deck card shoe for the blackjack datapath.
- Holds NUM_DECKS x 52 card values and performs an unbiased Fisher-Yates shuffle from an internal LFSR.
- Deals cards sequentially through a request/valid handshake.
- Tracks cards remaining and flags when the cut-card threshold is reached, so the game FSM can order a reshuffle.

Parameters:
- NUM_DECKS, 2, decks in shoe, legal range 1..4; N = 52*NUM_DECKS, AW = clog2(N).
- CUT_CARDS, 26, low_cards asserts when cards_left <= CUT_CARDS; must be < N.
- SEED, 16'hACE1, LFSR load value on reset; nonzero.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high.
- shuffle_start  in  1  one-cycle request to shuffle the whole shoe.
- deal_req  in  1  one-cycle request for the next card.
- deal_valid  out  1  one-cycle pulse; deal_card is valid in the same cycle.
- deal_card  out  4  card value: 1=Ace, 2..10, 11=J/Q/K.
- deal_empty  out  1  pulses with deal_valid when a deal is requested and the shoe is exhausted; deal_card is 0 then.
- busy  out  1  high in FILL, DRAW and SWAP.
- shuffled  out  1  high from shuffle completion until the next shuffle_start or reset.
- cards_left  out  AW+1  undealt cards, N - deal pointer.
- low_cards  out  1  cards_left <= CUT_CARDS.

Behaviour:
- Reset (sampled on a clock edge):
  - State goes to FILL, fill index 0, deal pointer 0.
  - LFSR loads SEED.
  - Outputs: deal_valid=0, deal_empty=0, deal_card=0, shuffled=0, busy=1, cards_left=N.
- LFSR:
  - 16-bit Galois, polynomial x^16+x^14+x^13+x^11+1.
  - Advances every cycle except during reset.
  - rnd = low AW bits.
- FILL:
  - Writes one entry per cycle: mem[k] = 1 if k%13==0; (k%13)+1 if k%13 in 1..9; else 11.
  - After k = N-1 goes to IDLE, so it takes N cycles.
  - shuffle_start and deal_req are ignored during FILL.
- IDLE (unshuffled) and READY (shuffled) both accept deals:
  - deal_req at edge t gives deal_valid=1 and deal_card=mem[ptr] during cycle t+1; ptr increments.
  - If ptr == N: deal_empty=1, deal_card=0, ptr unchanged.
- shuffle_start in IDLE/READY:
  - Sets ptr=0, shuffled=0, i=N-1, goes to DRAW.
  - If deal_req arrives in the same cycle, shuffle wins and the deal is dropped (no deal_valid).
- DRAW:
  - cand = rnd & mask(i), where mask(i) = 2^ceil(log2(i+1)) - 1.
  - If cand <= i: latch j = cand and go to SWAP. Otherwise stay in DRAW (rejection sampling, no modulo bias).
- SWAP (one cycle):
  - Swap mem[i] and mem[j]; j==i is legal and leaves the entry unchanged.
  - If i==1 go to READY and set shuffled=1; otherwise i = i-1 and return to DRAW.
- shuffle_start and deal_req are ignored while busy.
- deal_valid and deal_empty are single-cycle pulses and never assert without a preceding deal_req.
- Reset mid-FILL, mid-shuffle or mid-deal restarts FILL: the memory contents are rebuilt and all in-progress work is discarded.
- The shoe's multiset is invariant: dealing reads only, and shuffling permutes only.
- Determinism: identical reset-to-shuffle_start cycle distances produce identical deal sequences.

Test Plan:
1. NUM_DECKS=1: release reset and count cycles -> busy high for exactly 52 cycles, then busy=0, cards_left=52, shuffled=0. Deal 13 cards without shuffling -> sequence 1,2,...,10,11,11,11.
2. NUM_DECKS=2: shuffle, wait for shuffled=1, then deal 104 cards.
   - Value histogram must be: values 1..10 each 8, value 11 = 24.
   - Sequence must differ from the unshuffled order.
   - Cycles from shuffle_start to shuffled are >= 2*(N-1) = 206.
3. Deal 105 requests after a full deal-out -> 105th deal gives deal_valid=1, deal_empty=1, deal_card=0, cards_left=0. CUT_CARDS=26: low_cards rises on the deal that makes cards_left=26.
4. In READY, assert shuffle_start and deal_req in the same cycle -> no deal_valid, busy=1 next cycle, cards_left=N, shuffled=0.
5. Assert reset midway through a shuffle -> FILL restarts (busy for N cycles) and the ordered-deal check of scenario 1 passes. Repeating with the same timing gives an identical shuffled sequence.
6. deal_req and shuffle_start during busy -> no deal_valid, cards_left unchanged, shuffle completes normally.
